// File: rtl/fc_pkg.sv
// Shared types and post-processing helpers for the parametrised dense layer.
package fc_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, DRAIN} fc_state_t;

  function automatic logic signed [63:0] relu_fn(input logic signed [63:0] v, input bit en);
    return (en && v < 0) ? 64'sd0 : v;
  endfunction

  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Caller keeps the low w bits; without saturation that is plain truncation.
  function automatic logic signed [63:0] post_fn(input logic signed [63:0] v, input bit relu_en,
                                                 input bit sat_en, input int w);
    logic signed [63:0] r;
    r = relu_fn(v, relu_en);
    return sat_en ? sat_fn(r, w) : r;
  endfunction

endpackage

// File: rtl/fc_lane.sv
// One MAC lane: weight/bias ROM, per-group accumulators, bias/ReLU/reduce, result store.
// FC_LAYER_SAT_EN selects saturation instead of truncation when reducing to DATA_W.
module fc_lane
  import fc_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int WGT_W  = 9,
  parameter int ACC_W  = 36,
  parameter int GROUPS = 4,
  parameter int N_IN   = 100,
  parameter int RELU   = 1,
  parameter int AW     = 9,
  parameter int GW     = 2,
  parameter logic [N_IN*GROUPS*WGT_W-1:0] W_INIT = '0,
  parameter logic [GROUPS*WGT_W-1:0]      B_INIT = '0
) (
  input  logic                     clk,
  input  logic [AW-1:0]            w_addr,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     mac_en,
  input  logic                     first,
  input  logic                     bias_en,
  input  logic [GW-1:0]            grp,
  input  logic                     drain,
  input  logic [GW-1:0]            out_grp,
  output logic signed [DATA_W-1:0] y
);

`ifdef FC_LAYER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic signed [WGT_W-1:0]  w_p0;
  logic signed [ACC_W-1:0]  acc_p1 [GROUPS];
  logic signed [DATA_W-1:0] res_p2 [GROUPS];
  logic signed [ACC_W-1:0]  prod;
  logic signed [WGT_W-1:0]  bias;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] res;

  always_comb begin
    prod = ACC_W'(x) * ACC_W'(w_p0);
    bias = B_INIT[int'(grp)*WGT_W +: WGT_W];
    sum  = acc_p1[grp] + ACC_W'(bias);
    res  = DATA_W'(post_fn(64'(sum), RELU != 0, SAT_EN, DATA_W));
  end

  // p0: registered ROM read; p1: accumulate; p2: post-processed result
  always_ff @(posedge clk) begin
    w_p0 <= W_INIT[int'(w_addr)*WGT_W +: WGT_W];
    if (mac_en) acc_p1[grp] <= (first ? '0 : acc_p1[grp]) + prod;
    if (bias_en) res_p2[grp] <= res;
  end

  assign y = drain ? res_p2[out_grp] : '0;

endmodule

// File: rtl/fc_layer_param.sv
// Dense layer engine: FSM/counters plus LANES copies of fc_lane. ROM images come in as
// W_INIT/B_INIT parameters. FC_LAYER_SAT_EN enables output saturation (default: truncation).
module fc_layer_param
  import fc_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int GROUPS = 4,
  parameter int N_IN   = 100,
  parameter int DATA_W = 18,
  parameter int WGT_W  = 9,
  parameter int ACC_W  = 36,
  parameter int RELU   = 1,
  parameter logic [LANES*N_IN*GROUPS*WGT_W-1:0] W_INIT = '0,
  parameter logic [LANES*GROUPS*WGT_W-1:0]      B_INIT = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 strt,
  input  logic                                 abort,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_W-1:0]                    din,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*DATA_W-1:0]              dout,
  output logic [$clog2(GROUPS>1?GROUPS:2)-1:0] out_grp,
  output logic                                 busy
);

  localparam int GW = $clog2(GROUPS > 1 ? GROUPS : 2);
  localparam int IW = $clog2(N_IN > 1 ? N_IN : 2);
  localparam int AW = $clog2(N_IN*GROUPS > 1 ? N_IN*GROUPS : 2);

  fc_state_t                state;
  logic [IW-1:0]            in_idx;
  logic [GW-1:0]            grp;
  logic signed [DATA_W-1:0] din_p0;
  logic [AW-1:0]            rom_addr;
  logic                     last_grp, last_in, last_beat;

  assign last_grp  = (grp == GW'(GROUPS - 1));
  assign last_in   = (in_idx == IW'(N_IN - 1));
  assign last_beat = (out_grp == GW'(GROUPS - 1));

  // Address runs one cycle ahead of the MAC: word 0 on the load handshake, then grp+1.
  always_comb begin
    rom_addr = '0;
    if (state == LOAD) rom_addr = AW'(int'(in_idx) * GROUPS);
    else if (state == MAC && !last_grp) rom_addr = AW'(int'(in_idx) * GROUPS + int'(grp) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= IDLE;
      in_idx    <= '0;
      grp       <= '0;
      out_grp   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (strt) begin
          state    <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        LOAD: if (in_valid) begin
          state    <= MAC;
          in_ready <= 1'b0;
          grp      <= '0;
        end
        MAC: if (last_grp) begin
          grp <= '0;
          if (last_in) begin
            in_idx <= '0;
            state  <= BIAS;
          end else begin
            in_idx   <= in_idx + IW'(1);
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end else grp <= grp + GW'(1);
        BIAS: if (last_grp) begin
          grp       <= '0;
          state     <= DRAIN;
          out_valid <= 1'b1;
          out_grp   <= '0;
        end else grp <= grp + GW'(1);
        DRAIN: if (out_ready) begin
          if (last_beat) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_grp   <= '0;
          end else out_grp <= out_grp + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0: input activation latched on the handshake
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) din_p0 <= din;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] lane_y;

    fc_lane #(
      .DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .GROUPS(GROUPS), .N_IN(N_IN),
      .RELU(RELU), .AW(AW), .GW(GW),
      .W_INIT(W_INIT[i*N_IN*GROUPS*WGT_W +: N_IN*GROUPS*WGT_W]),
      .B_INIT(B_INIT[i*GROUPS*WGT_W +: GROUPS*WGT_W])
    ) u_lane (
      .clk    (clk),
      .w_addr (rom_addr),
      .x      (din_p0),
      .mac_en (state == MAC),
      .first  (in_idx == '0),
      .bias_en(state == BIAS),
      .grp    (grp),
      .drain  (out_valid),
      .out_grp(out_grp),
      .y      (lane_y)
    );

    assign dout[i*DATA_W +: DATA_W] = lane_y;
  end

endmodule
